// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - types shared across the router datapath
package router_pkg;

  typedef enum logic [1:0] {
    GS_IDLE    = 2'd0,
    GS_ROUTING = 2'd1,
    GS_WAITING = 2'd2,
    GS_ACTIVE  = 2'd3
  } GLOBAL_STATE_t;

endpackage

// File: rtl/output_unit_vc.sv
// rtl/output_unit_vc.sv - output-port VC allocation, per-VC credit tracking, optional WAITING timeout
// Build option: define OUTPUT_UNIT_VC_TIMEOUT_EN to compile in the per-VC WAITING timeout.
module output_unit_vc #(
  parameter int NUM_VC         = 2,
  parameter int CREDIT_DEPTH   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int VC_W          = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W         = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_VC-1:0]                      i_switch_req,
  output logic [NUM_VC-1:0]                      o_switch_ack,
  output logic [NUM_VC-1:0]                      o_downstream_req,
  input  logic [NUM_VC-1:0]                      i_downstream_ack,
  input  logic                                   i_flit_valid,
  input  logic [VC_W-1:0]                        i_flit_vc,
  input  logic                                   i_flit_tail,
  input  logic                                   i_credit_valid,
  input  logic [VC_W-1:0]                        i_credit_vc,
  output logic [NUM_VC-1:0]                      o_credit_avail,
  output router_pkg::GLOBAL_STATE_t [NUM_VC-1:0] o_gstate,
  output logic                                   o_err,
  output logic [NUM_VC-1:0]                      o_timeout
);

  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_WAITING = 2'd2;
  localparam logic [1:0]       S_ACTIVE  = 2'd3;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CREDIT_DEPTH);

  if (NUM_VC < 1 || NUM_VC > 8 || CREDIT_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("output_unit_vc: parameter out of range");
  end

  logic [NUM_VC-1:0][1:0]       st_q;
  logic [NUM_VC-1:0][CNT_W-1:0] cnt_q;
  logic [VC_W-1:0]              ptr_q;
  logic                         err_q;

  logic [NUM_VC-1:0] is_idle;
  logic [NUM_VC-1:0] is_waiting;
  logic [NUM_VC-1:0] is_active;
  logic [NUM_VC-1:0] flit_acc;
  logic [NUM_VC-1:0] credit_hit;
  logic [NUM_VC-1:0] credit_ovf;
  logic [NUM_VC-1:0] grant_vec;
  logic [NUM_VC-1:0] timeout_hit;
  logic              flit_err;
  logic              credit_err;
  logic              grant_any;
  logic [VC_W-1:0]   grant_idx;
  logic [VC_W-1:0]   ptr_next;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      is_idle[v]    = (st_q[v] == S_IDLE);
      is_waiting[v] = (st_q[v] == S_WAITING);
      is_active[v]  = (st_q[v] == S_ACTIVE);
    end
  end

  // A flit plus a credit on a full counter nets to zero, so it is not an overflow.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      flit_acc[v]   = i_flit_valid && (i_flit_vc == VC_W'(v)) && is_active[v] && (cnt_q[v] != '0);
      credit_hit[v] = i_credit_valid && (i_credit_vc == VC_W'(v));
      credit_ovf[v] = credit_hit[v] && (cnt_q[v] == CNT_FULL) && !flit_acc[v];
    end
    flit_err   = i_flit_valid && (flit_acc == '0);
    credit_err = (credit_ovf != '0) || (i_credit_valid && (credit_hit == '0));
  end

  // Round-robin search from the pointer; only one VC may be WAITING at a time.
  always_comb begin
    int cand;
    cand      = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_VC) cand = cand - NUM_VC;
      if (!grant_any && is_idle[cand] && i_switch_req[cand]) begin
        grant_any = 1'b1;
        grant_idx = VC_W'(cand);
      end
    end
    if (is_waiting != '0) grant_any = 1'b0;
    if (grant_any) grant_vec[grant_idx] = 1'b1;
    ptr_next = (int'(grant_idx) == NUM_VC - 1) ? '0 : grant_idx + VC_W'(1);
  end

`ifdef OUTPUT_UNIT_VC_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [NUM_VC-1:0][TO_W-1:0] wait_cnt_q;
  logic [NUM_VC-1:0]           timeout_q;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      timeout_hit[v] = is_waiting[v] && !i_downstream_ack[v] && (wait_cnt_q[v] == TO_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= '0;
    end else begin
      timeout_q <= timeout_hit;
      for (int v = 0; v < NUM_VC; v++) begin
        if (is_waiting[v] && !i_downstream_ack[v] && !timeout_hit[v]) begin
          wait_cnt_q[v] <= wait_cnt_q[v] + TO_W'(1);
        end else begin
          wait_cnt_q[v] <= '0;
        end
      end
    end
  end

  assign o_timeout = timeout_q;
`else
  assign timeout_hit = '0;
  assign o_timeout   = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= '0;
      cnt_q <= {NUM_VC{CNT_FULL}};
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= flit_err || credit_err;
      if (grant_any) ptr_q <= ptr_next;
      for (int v = 0; v < NUM_VC; v++) begin
        case (st_q[v])
          S_IDLE: begin
            if (grant_vec[v]) st_q[v] <= S_WAITING;
          end
          S_WAITING: begin
            if (i_downstream_ack[v]) st_q[v] <= S_ACTIVE;
            else if (timeout_hit[v]) st_q[v] <= S_IDLE;
          end
          S_ACTIVE: begin
            if (flit_acc[v] && i_flit_tail) st_q[v] <= S_IDLE;
          end
          default: st_q[v] <= S_IDLE;
        endcase
        if (flit_acc[v] && !(credit_hit[v] && !credit_ovf[v])) begin
          cnt_q[v] <= cnt_q[v] - CNT_W'(1);
        end else if (!flit_acc[v] && credit_hit[v] && !credit_ovf[v]) begin
          cnt_q[v] <= cnt_q[v] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      o_gstate[v]       = router_pkg::GLOBAL_STATE_t'(st_q[v]);
      o_credit_avail[v] = (cnt_q[v] != '0);
    end
  end

  assign o_downstream_req = is_waiting;
  assign o_switch_ack     = is_waiting & i_downstream_ack;
  assign o_err            = err_q;

endmodule

// File: tb/tb_output_unit_vc.sv
// tb/tb_output_unit_vc.sv - self-checking bench for output_unit_vc against a behavioural model
module tb_output_unit_vc;
  import router_pkg::*;

  localparam int NUM_VC         = 2;
  localparam int CREDIT_DEPTH   = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic [NUM_VC-1:0]           switch_req = '0;
  logic [NUM_VC-1:0]           switch_ack;
  logic [NUM_VC-1:0]           dreq;
  logic [NUM_VC-1:0]           dack = '0;
  logic                        flit_valid = 1'b0;
  logic [0:0]                  flit_vc = '0;
  logic                        flit_tail = 1'b0;
  logic                        credit_valid = 1'b0;
  logic [0:0]                  credit_vc = '0;
  logic [NUM_VC-1:0]           credit_avail;
  GLOBAL_STATE_t [NUM_VC-1:0]  gstate;
  logic                        err;
  logic [NUM_VC-1:0]           timeout;

  always #5 clk = ~clk;

  output_unit_vc #(
    .NUM_VC(NUM_VC),
    .CREDIT_DEPTH(CREDIT_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .i_switch_req(switch_req),
    .o_switch_ack(switch_ack),
    .o_downstream_req(dreq),
    .i_downstream_ack(dack),
    .i_flit_valid(flit_valid),
    .i_flit_vc(flit_vc),
    .i_flit_tail(flit_tail),
    .i_credit_valid(credit_valid),
    .i_credit_vc(credit_vc),
    .o_credit_avail(credit_avail),
    .o_gstate(gstate),
    .o_err(err),
    .o_timeout(timeout)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-VC state and credit count as plain integers.
  GLOBAL_STATE_t     m_st [NUM_VC];
  GLOBAL_STATE_t     n_st [NUM_VC];
  int                m_cr [NUM_VC];
  int                n_cr [NUM_VC];
  int                m_ptr, m_wait, waiter, fv, cv, c;
  logic              m_err, e, done;
  logic [NUM_VC-1:0] m_to;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        m_st[v] = GS_IDLE;
        m_cr[v] = CREDIT_DEPTH;
      end
      m_ptr = 0; m_wait = 0; m_err = 1'b0; m_to = '0;
    end else begin
      n_st = m_st; n_cr = m_cr; e = 1'b0; m_to = '0; waiter = -1;
      for (int v = 0; v < NUM_VC; v++) if (m_st[v] == GS_WAITING) waiter = v;
      if (flit_valid) begin
        fv = int'(flit_vc);
        if (fv < NUM_VC && m_st[fv] == GS_ACTIVE && m_cr[fv] > 0) begin
          n_cr[fv]--;
          if (flit_tail) n_st[fv] = GS_IDLE;
        end else e = 1'b1;
      end
      if (credit_valid) begin
        cv = int'(credit_vc);
        if (cv >= NUM_VC || n_cr[cv] == CREDIT_DEPTH) e = 1'b1;
        else n_cr[cv]++;
      end
      if (waiter >= 0) begin
        if (dack[waiter]) n_st[waiter] = GS_ACTIVE;
`ifdef OUTPUT_UNIT_VC_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TIMEOUT_CYCLES) begin
            n_st[waiter] = GS_IDLE;
            m_to[waiter] = 1'b1;
          end
        end
`endif
      end else begin
        done = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
          c = (m_ptr + k) % NUM_VC;
          if (!done && m_st[c] == GS_IDLE && switch_req[c]) begin
            n_st[c] = GS_WAITING;
            m_ptr = (c + 1) % NUM_VC;
            m_wait = 0;
            done = 1'b1;
          end
        end
      end
      m_st = n_st; m_cr = n_cr; m_err = e;
    end
  end

  always @(negedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      check($sformatf("model_gstate[%0d]", v), 32'(gstate[v]), 32'(m_st[v]));
      check($sformatf("model_avail[%0d]", v), 32'(credit_avail[v]), 32'(m_cr[v] > 0));
      check($sformatf("model_dreq[%0d]", v), 32'(dreq[v]), 32'(m_st[v] == GS_WAITING));
      check($sformatf("model_sack[%0d]", v), 32'(switch_ack[v]), 32'(m_st[v] == GS_WAITING && dack[v]));
      check($sformatf("model_timeout[%0d]", v), 32'(timeout[v]), 32'(m_to[v]));
    end
    check("model_err", 32'(err), 32'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    switch_req = 2'b11;
    dack       = 2'b11;
    tick();
    check("rst_gstate0", 32'(gstate[0]), 32'(GS_IDLE));
    check("rst_gstate1", 32'(gstate[1]), 32'(GS_IDLE));
    check("rst_avail", 32'(credit_avail), 32'h3);
    check("rst_dreq", 32'(dreq), 32'h0);
    check("rst_sack", 32'(switch_ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    dack    = 2'b00;
    reset_n = 1'b1;

    tick();
    check("arb_vc0_first", 32'(gstate[0]), 32'(GS_WAITING));
    check("arb_vc1_idle", 32'(gstate[1]), 32'(GS_IDLE));
    for (int i = 0; i < 3; i++) begin
      check("wait_dreq", 32'(dreq), 32'h1);
      check("wait_sack_low", 32'(switch_ack), 32'h0);
      tick();
    end
    dack = 2'b01;
    #1;
    check("ack_dreq", 32'(dreq), 32'h1);
    check("ack_sack_vc0", 32'(switch_ack), 32'h1);
    tick();
    dack = 2'b00;
    check("vc0_active", 32'(gstate[0]), 32'(GS_ACTIVE));
    check("vc1_still_idle", 32'(gstate[1]), 32'(GS_IDLE));
    tick();
    check("vc1_waiting", 32'(gstate[1]), 32'(GS_WAITING));
    dack = 2'b10;
    #1;
    check("ack_sack_vc1", 32'(switch_ack), 32'h2);
    tick();
    dack = 2'b00;
    switch_req = 2'b00;
    check("vc1_active", 32'(gstate[1]), 32'(GS_ACTIVE));

    flit_valid = 1'b1; flit_vc = 1'b1; flit_tail = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("vc1_credits_gone", 32'(credit_avail), 32'h1);
    check("no_err_4_flits", 32'(err), 32'h0);
    tick();
    check("err_5th_flit", 32'(err), 32'h1);
    check("vc1_active_after_drop", 32'(gstate[1]), 32'(GS_ACTIVE));
    check("avail_after_drop", 32'(credit_avail), 32'h1);
    flit_valid = 1'b0;
    tick();
    check("err_one_pulse", 32'(err), 32'h0);

    credit_valid = 1'b1; credit_vc = 1'b1;
    tick();
    check("credit_back_vc1", 32'(credit_avail), 32'h3);
    tick();
    flit_valid = 1'b1; flit_vc = 1'b1;
    tick();
    credit_valid = 1'b0;
    tick();
    check("count_after_mix", 32'(credit_avail), 32'h3);
    tick();
    check("count2_exhausted", 32'(credit_avail), 32'h1);
    check("no_err_mix", 32'(err), 32'h0);
    flit_valid = 1'b0;

    credit_valid = 1'b1; credit_vc = 1'b0;
    tick();
    check("err_credit_sat", 32'(err), 32'h1);
    credit_valid = 1'b0;
    tick();
    check("err_sat_one_pulse", 32'(err), 32'h0);

    flit_valid = 1'b1; flit_vc = 1'b0; flit_tail = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("vc0_one_left", 32'(credit_avail), 32'h1);
    flit_tail = 1'b1;
    tick();
    flit_valid = 1'b0; flit_tail = 1'b0;
    check("tail_vc0_idle", 32'(gstate[0]), 32'(GS_IDLE));
    check("sat_then_drain", 32'(credit_avail), 32'h0);

    credit_valid = 1'b1; credit_vc = 1'b1;
    tick();
    credit_valid = 1'b0;
    flit_valid = 1'b1; flit_vc = 1'b1; flit_tail = 1'b1;
    tick();
    flit_valid = 1'b0; flit_tail = 1'b0;
    check("tail_vc1_idle", 32'(gstate[1]), 32'(GS_IDLE));
    switch_req = 2'b11;
    tick();
    check("ptr0_vc0_wins", 32'(gstate[0]), 32'(GS_WAITING));
    check("ptr0_vc1_idle", 32'(gstate[1]), 32'(GS_IDLE));
    dack = 2'b01;
    tick();
    dack = 2'b00;
    tick();
    dack = 2'b10;
    tick();
    dack = 2'b00; switch_req = 2'b00;
    credit_valid = 1'b1; credit_vc = 1'b1;
    tick();
    credit_valid = 1'b0;
    flit_valid = 1'b1; flit_vc = 1'b1;
    tick();
    check("pre_reset_vc1_active", 32'(gstate[1]), 32'(GS_ACTIVE));
    reset_n = 1'b0;
    #1;
    check("async_rst_gstate0", 32'(gstate[0]), 32'(GS_IDLE));
    check("async_rst_gstate1", 32'(gstate[1]), 32'(GS_IDLE));
    check("async_rst_avail", 32'(credit_avail), 32'h3);
    check("async_rst_dreq", 32'(dreq), 32'h0);
    flit_valid = 1'b0;
    tick();
    reset_n = 1'b1;

    switch_req = 2'b01;
    tick();
    switch_req = 2'b00;
    check("to_vc0_waiting", 32'(gstate[0]), 32'(GS_WAITING));
    for (int i = 0; i < 16; i++) tick();
`ifdef OUTPUT_UNIT_VC_TIMEOUT_EN
    check("to_vc0_idle", 32'(gstate[0]), 32'(GS_IDLE));
    check("to_pulse", 32'(timeout), 32'h1);
    tick();
    check("to_pulse_once", 32'(timeout), 32'h0);
`else
    check("no_to_still_waiting", 32'(gstate[0]), 32'(GS_WAITING));
    check("no_to_pulse", 32'(timeout), 32'h0);
    for (int i = 0; i < 24; i++) tick();
    check("no_to_long_wait", 32'(gstate[0]), 32'(GS_WAITING));
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_unit_vc.md
OUTPUT_UNIT_VC -- requirements
Module: output_unit_vc

Interface
- REQ-001: Parameter NUM_VC, default 2; number of virtual channels served by this output port (range 1..8).
- REQ-002: Parameter CREDIT_DEPTH, default 4; downstream buffer slots per VC, which is the reset credit count.
- REQ-003: Parameter TIMEOUT_CYCLES, default 16; WAITING timeout limit. Used only when the timeout feature is compiled in.
- REQ-004: clk  in  1  single clock; all state updates on its rising edge.
- REQ-005: reset_n  in  1  asynchronous, active-low reset.
- REQ-006: i_switch_req  in  NUM_VC  per-VC request to acquire the downstream VC.
- REQ-007: o_switch_ack  out  NUM_VC  per-VC one-cycle grant pulse.
- REQ-008: o_downstream_req  out  NUM_VC  per-VC allocation request to the downstream router.
- REQ-009: i_downstream_ack  in  NUM_VC  per-VC allocation acknowledge from downstream.
- REQ-010: i_flit_valid  in  1  a flit is being sent through the output this cycle.
- REQ-011: i_flit_vc  in  $clog2(NUM_VC) (minimum 1 bit)  VC of that flit.
- REQ-012: i_flit_tail  in  1  the flit is a tail flit.
- REQ-013: i_credit_valid  in  1  one credit returned from downstream.
- REQ-014: i_credit_vc  in  $clog2(NUM_VC) (minimum 1 bit)  VC of the returned credit.
- REQ-015: o_credit_avail  out  NUM_VC  per-VC flag, high when that VC's credit count is nonzero.
- REQ-016: o_gstate  out  NUM_VC x GLOBAL_STATE_t (router_pkg)  per-VC current state.
- REQ-017: o_err  out  1  one-cycle protocol-error pulse.
- REQ-018: o_timeout  out  NUM_VC  per-VC one-cycle timeout pulse.

Function
- REQ-019: Each VC SHALL run its own FSM with states IDLE, WAITING and ACTIVE. ROUTING SHALL never be entered; an illegal state SHALL return to IDLE on the next clock.
- REQ-020: At most one VC SHALL be in WAITING at any time.
- REQ-021: When IDLE VCs are requesting and no VC is WAITING, a round-robin arbiter SHALL move exactly one requesting VC to WAITING. The search starts at the pointer, and the pointer then advances to winner+1 mod NUM_VC. The pointer resets to 0.
- REQ-022: In WAITING, o_downstream_req[v] SHALL be 1; it SHALL be 0 in every other state.
- REQ-023: In WAITING with i_downstream_ack[v]=1, o_switch_ack[v] SHALL pulse in the same cycle, and the VC SHALL be ACTIVE on the next clock.
- REQ-024: In ACTIVE, a flit with i_flit_valid=1 and i_flit_tail=1 on that VC SHALL return the VC to IDLE on the next clock.
- REQ-025: Each VC SHALL keep a credit counter of width $clog2(CREDIT_DEPTH+1), reset to CREDIT_DEPTH.
  - An accepted flit decrements it by 1.
  - A returned credit increments it by 1.
  - A flit and a credit on the same VC in the same cycle leave it unchanged.
- REQ-026: A flit SHALL be accepted only if its VC is ACTIVE with a nonzero credit count. Otherwise the flit SHALL be ignored (no counter or state change) and o_err SHALL pulse on the next cycle.
- REQ-027: A credit returned to a counter already at CREDIT_DEPTH SHALL saturate, and o_err SHALL pulse on the next cycle.
- REQ-028: o_credit_avail and o_gstate SHALL be registered-state derived, with no combinational path from inputs.

Reset
- REQ-029: While reset_n=0, the following SHALL hold immediately and asynchronously:
  - every VC is IDLE and every credit counter is CREDIT_DEPTH;
  - o_switch_ack, o_downstream_req, o_err and o_timeout are 0;
  - o_credit_avail is all ones.
- REQ-030: Reset asserted mid-packet SHALL abandon all allocations; there is no state retention.

Configuration
- REQ-031: With OUTPUT_UNIT_VC_TIMEOUT_EN defined:
  - a per-VC counter SHALL count consecutive WAITING cycles without an ack;
  - on reaching TIMEOUT_CYCLES, the VC SHALL return to IDLE and o_timeout[v] SHALL pulse once;
  - the arbiter SHALL treat the VC as newly requesting.
- REQ-032: Without OUTPUT_UNIT_VC_TIMEOUT_EN, WAITING SHALL persist until ack, o_timeout SHALL be tied 0, and no timeout counter SHALL be synthesised.

Verification
- REQ-033: Apply i_switch_req=2'b11 after reset -> VC0 enters WAITING first. After VC0 is acked, VC1 enters WAITING. Pointer = 0 after the VC1 grant.
- REQ-034: With VC0 WAITING, hold ack low 3 cycles, then high -> o_downstream_req[0] is high for 4 cycles, o_switch_ack[0] pulses on the ack cycle, and gstate[0]=ACTIVE next.
- REQ-035: With VC1 ACTIVE, send 4 flits with no credits returned -> o_credit_avail[1]=0. A 5th flit is ignored and o_err pulses once.
- REQ-036: With count 2, apply a flit and a credit on the same VC in the same cycle -> count stays 2. A credit at count 4 -> count stays 4 and o_err pulses.
- REQ-037: Send a tail flit on VC0 ACTIVE -> IDLE next cycle. Then assert reset mid-packet on VC1 -> all IDLE and credits = 4 immediately.
- REQ-038: With TIMEOUT_EN defined and no ack -> o_timeout[0] pulses after 16 WAITING cycles and VC0 returns to IDLE. With TIMEOUT_EN undefined -> VC0 remains WAITING indefinitely.
